// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with a start/done handshake and an overflow/borrow flag.
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  ov_bw,
    output logic                  invalid
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry, carry_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               busy_d, done_d, ov_bw_d, invalid_d;
    logic [W-1:0]       result_d;

    logic [3:0]         a_dig, b_dig, b_adj, dig_sum;
    logic [4:0]         t;
    logic               carry_nx;
    logic               in_invalid;
    logic               last_digit;

    // Current-digit arithmetic; subtraction adds the nine's complement of b.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        b_adj = sub_q ? 4'(4'd9 - b_dig) : b_dig;
        t     = 5'(a_dig) + 5'(b_adj) + 5'(carry);
        // Decimal carry is decided by t > 9, so invalid digits still behave deterministically.
        if (t > 5'd9) begin
            dig_sum  = 4'(t + 5'd6);
            carry_nx = 1'b1;
        end else begin
            dig_sum  = t[3:0];
            carry_nx = 1'b0;
        end
        last_digit = (idx == IDX_W'(DIGITS - 1));
    end

    // Non-BCD digit detection on the operands being latched.
    always_comb begin
        in_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                in_invalid = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        carry_d   = carry;
        idx_d     = idx;
        busy_d    = busy;
        done_d    = 1'b0;
        result_d  = result;
        ov_bw_d   = ov_bw;
        invalid_d = invalid;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    a_d       = a;
                    b_d       = b;
                    sub_d     = sub;
                    carry_d   = sub;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    result_d  = '0;
                    ov_bw_d   = 1'b0;
                    invalid_d = in_invalid;
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx == IDX_W'(i)) begin
                        result_d[4*i +: 4] = dig_sum;
                    end
                end
                carry_d = carry_nx;
                idx_d   = idx + IDX_W'(1);
                if (last_digit) begin
                    state_d = DONE_S;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    ov_bw_d = sub_q ? ~carry_nx : carry_nx;
                end
            end
            DONE_S: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ov_bw   <= 1'b0;
            invalid <= 1'b0;
        end else begin
            state   <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry   <= carry_d;
            idx     <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            result  <= result_d;
            ov_bw   <= ov_bw_d;
            invalid <= invalid_d;
        end
    end

endmodule
